// File: rtl/msg_pkg.sv
// Shared types and arithmetic helpers for the message length controller.
package msg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } msg_state_t;

  localparam int unsigned MAX_KEEP_W = 64;
  localparam int unsigned POP_W      = 7;
  localparam int unsigned ARITH_W    = 32;

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_KEEP_W-1:0] keep);
    logic [POP_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < int'(MAX_KEEP_W); i++) begin
      cnt = cnt + POP_W'(keep[i]);
    end
    return cnt;
  endfunction

  // Clamp a + b to max; operands are zero-extended counts.
  function automatic logic [ARITH_W-1:0] sat_add(input logic [ARITH_W-1:0] a,
                                                 input logic [ARITH_W-1:0] b,
                                                 input logic [ARITH_W-1:0] max);
    logic [ARITH_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max}) ? max : sum[ARITH_W-1:0];
  endfunction

  function automatic logic sat_hit(input logic [ARITH_W-1:0] a,
                                   input logic [ARITH_W-1:0] b,
                                   input logic [ARITH_W-1:0] max);
    return ({1'b0, a} + {1'b0, b}) > {1'b0, max};
  endfunction

endpackage

// File: rtl/keep_popcount.sv
// Combinational count of enabled bytes in one beat's tkeep.
module keep_popcount
  import msg_pkg::*;
#(
  parameter int unsigned TKEEP_WIDTH = 8,
  localparam int unsigned CNT_W      = $clog2(TKEEP_WIDTH + 1)
) (
  input  logic [TKEEP_WIDTH-1:0] keep,
  output logic [CNT_W-1:0]       count_c
);

  assign count_c = CNT_W'(popcount(MAX_KEEP_W'(keep)));

endmodule

// File: rtl/msg_len_ctrl.sv
// Frames an AXI-Stream on tlast, accumulates byte/beat counts per message and
// presents each finished length as a valid/ready record with upstream back-pressure.
module msg_len_ctrl
  import msg_pkg::*;
#(
  parameter int unsigned NUM_COUNT_BITS = 16,
  parameter int unsigned TKEEP_WIDTH    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      s_tvalid,
  input  logic                      s_tlast,
  input  logic [TKEEP_WIDTH-1:0]    s_tkeep,
  input  logic                      dn_tready,
  output logic                      s_tready,
  output logic                      count_en,
  output logic                      msg_valid,
  output logic                      msg_active,
  output logic                      len_valid,
  input  logic                      len_ready,
  output logic [NUM_COUNT_BITS-1:0] len_data,
  output logic [NUM_COUNT_BITS-1:0] len_beats,
  output logic                      len_ovf
);

  localparam int unsigned CNT_W = $clog2(TKEEP_WIDTH + 1);
  localparam logic [ARITH_W-1:0] MAX_COUNT =
    ARITH_W'((64'(1) << NUM_COUNT_BITS) - 64'(1));

  msg_state_t state_q, state_d;

  logic [NUM_COUNT_BITS-1:0] bytes_q, bytes_d;
  logic [NUM_COUNT_BITS-1:0] beats_q, beats_d;
  logic                      ovf_q, ovf_d;
  logic                      len_valid_q, len_valid_d;
  logic [NUM_COUNT_BITS-1:0] len_data_q, len_data_d;
  logic [NUM_COUNT_BITS-1:0] len_beats_q, len_beats_d;
  logic                      len_ovf_q, len_ovf_d;

  logic                      stall;
  logic                      acc;
  logic [CNT_W-1:0]          keep_cnt;
  logic [NUM_COUNT_BITS-1:0] bytes_nxt;
  logic [NUM_COUNT_BITS-1:0] beats_nxt;
  logic                      ovf_nxt;

  keep_popcount #(
    .TKEEP_WIDTH (TKEEP_WIDTH)
  ) u_keep_popcount (
    .keep    (s_tkeep),
    .count_c (keep_cnt)
  );

  assign stall = len_valid_q & ~len_ready;
  assign acc   = s_tvalid & s_tready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a single-beat message never leaves IDLE
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = IDLE;
    end else if (acc) begin
      state_d = s_tlast ? IDLE : ACCUM;
    end
  end

  // Handshake strobes and status outputs
  always_comb begin
    s_tready   = dn_tready & ~stall;
    count_en   = s_tvalid & s_tready;
    msg_valid  = s_tvalid & s_tready & s_tlast;
    msg_active = (state_q == ACCUM);
  end

  always_comb begin
    bytes_nxt = NUM_COUNT_BITS'(sat_add(ARITH_W'(bytes_q), ARITH_W'(keep_cnt), MAX_COUNT));
    beats_nxt = NUM_COUNT_BITS'(sat_add(ARITH_W'(beats_q), ARITH_W'(1), MAX_COUNT));
    ovf_nxt   = ovf_q
              | sat_hit(ARITH_W'(bytes_q), ARITH_W'(keep_cnt), MAX_COUNT)
              | sat_hit(ARITH_W'(beats_q), ARITH_W'(1), MAX_COUNT);
  end

  // Accumulators and length record; clr overrides any accepted beat
  always_comb begin
    bytes_d     = bytes_q;
    beats_d     = beats_q;
    ovf_d       = ovf_q;
    len_valid_d = len_valid_q;
    len_data_d  = len_data_q;
    len_beats_d = len_beats_q;
    len_ovf_d   = len_ovf_q;
    if (clr) begin
      bytes_d     = '0;
      beats_d     = '0;
      ovf_d       = 1'b0;
      len_valid_d = 1'b0;
      len_data_d  = '0;
      len_beats_d = '0;
      len_ovf_d   = 1'b0;
    end else begin
      if (len_valid_q && len_ready) begin
        len_valid_d = 1'b0;
      end
      if (acc) begin
        if (s_tlast) begin
          len_valid_d = 1'b1;
          len_data_d  = bytes_nxt;
          len_beats_d = beats_nxt;
          len_ovf_d   = ovf_nxt;
          bytes_d     = '0;
          beats_d     = '0;
          ovf_d       = 1'b0;
        end else begin
          bytes_d = bytes_nxt;
          beats_d = beats_nxt;
          ovf_d   = ovf_nxt;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bytes_q     <= '0;
      beats_q     <= '0;
      ovf_q       <= 1'b0;
      len_valid_q <= 1'b0;
      len_data_q  <= '0;
      len_beats_q <= '0;
      len_ovf_q   <= 1'b0;
    end else begin
      bytes_q     <= bytes_d;
      beats_q     <= beats_d;
      ovf_q       <= ovf_d;
      len_valid_q <= len_valid_d;
      len_data_q  <= len_data_d;
      len_beats_q <= len_beats_d;
      len_ovf_q   <= len_ovf_d;
    end
  end

  assign len_valid = len_valid_q;
  assign len_data  = len_data_q;
  assign len_beats = len_beats_q;
  assign len_ovf   = len_ovf_q;

endmodule

// File: tb/tb_msg_len_ctrl.sv
// Bench for msg_len_ctrl: a 16-bit and a 4-bit counter instance share one stimulus
// stream and are checked against a message-level reference model.
module tb_msg_len_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic       s_tvalid;
  logic       s_tlast;
  logic [7:0] s_tkeep;
  logic       dn_tready;
  logic       len_ready;

  logic        a_tready, a_count_en, a_msg_valid, a_active, a_len_valid, a_len_ovf;
  logic [15:0] a_len_data, a_len_beats;
  logic        b_tready, b_count_en, b_msg_valid, b_active, b_len_valid, b_len_ovf;
  logic [3:0]  b_len_data, b_len_beats;

  int total = 0;
  int bad   = 0;

  // Reference model state: raw (unbounded) totals of the open message and pending record
  int m_sum, m_n, rec_sum, rec_n;
  bit m_lv, m_active;

  msg_len_ctrl #(.NUM_COUNT_BITS(16), .TKEEP_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tkeep(s_tkeep), .dn_tready(dn_tready), .s_tready(a_tready),
    .count_en(a_count_en), .msg_valid(a_msg_valid), .msg_active(a_active),
    .len_valid(a_len_valid), .len_ready(len_ready), .len_data(a_len_data),
    .len_beats(a_len_beats), .len_ovf(a_len_ovf)
  );

  msg_len_ctrl #(.NUM_COUNT_BITS(4), .TKEEP_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tkeep(s_tkeep), .dn_tready(dn_tready), .s_tready(b_tready),
    .count_en(b_count_en), .msg_valid(b_msg_valid), .msg_active(b_active),
    .len_valid(b_len_valid), .len_ready(len_ready), .len_data(b_len_data),
    .len_beats(b_len_beats), .len_ovf(b_len_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic int clampv(input int v, input int max);
    return (v > max) ? max : v;
  endfunction

  task automatic check_regs();
    chk("a.len_valid", 32'(a_len_valid), 32'(m_lv));
    chk("b.len_valid", 32'(b_len_valid), 32'(m_lv));
    chk("a.msg_active", 32'(a_active), 32'(m_active));
    chk("b.msg_active", 32'(b_active), 32'(m_active));
    if (m_lv) begin
      chk("a.len_data",  32'(a_len_data),  32'(clampv(rec_sum, 65535)));
      chk("a.len_beats", 32'(a_len_beats), 32'(clampv(rec_n, 65535)));
      chk("a.len_ovf",   32'(a_len_ovf),   32'((rec_sum > 65535) || (rec_n > 65535)));
      chk("b.len_data",  32'(b_len_data),  32'(clampv(rec_sum, 15)));
      chk("b.len_beats", 32'(b_len_beats), 32'(clampv(rec_n, 15)));
      chk("b.len_ovf",   32'(b_len_ovf),   32'((rec_sum > 15) || (rec_n > 15)));
    end
  endtask

  // One clock of stimulus: check combinational strobes, advance model, check registers
  task automatic cycle(input logic tv, input logic tl, input logic [7:0] kp,
                       input logic dr, input logic lr, input logic cl);
    bit e_tr, e_acc;
    @(negedge clk);
    s_tvalid = tv; s_tlast = tl; s_tkeep = kp; dn_tready = dr; len_ready = lr; clr = cl;
    #1;
    e_tr  = dr & ~(m_lv & ~lr);
    e_acc = tv & e_tr;
    chk("a.s_tready",  32'(a_tready),    32'(e_tr));
    chk("b.s_tready",  32'(b_tready),    32'(e_tr));
    chk("a.count_en",  32'(a_count_en),  32'(e_acc));
    chk("b.count_en",  32'(b_count_en),  32'(e_acc));
    chk("a.msg_valid", 32'(a_msg_valid), 32'(e_acc & tl));
    chk("b.msg_valid", 32'(b_msg_valid), 32'(e_acc & tl));
    if (cl) begin
      m_lv = 0; m_sum = 0; m_n = 0; m_active = 0;
    end else begin
      if (m_lv && lr) m_lv = 0;
      if (e_acc) begin
        m_sum += $countones(kp);
        m_n   += 1;
        if (tl) begin
          rec_sum = m_sum; rec_n = m_n; m_lv = 1;
          m_sum = 0; m_n = 0; m_active = 0;
        end else begin
          m_active = 1;
        end
      end
    end
    @(posedge clk);
    #1;
    check_regs();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    s_tvalid = 0; s_tlast = 0; s_tkeep = '0; dn_tready = 1; len_ready = 0; clr = 0;
    rst = 0;
    #1;
    chk("rst.a.len_valid", 32'(a_len_valid), 32'd0);
    chk("rst.a.len_data",  32'(a_len_data),  32'd0);
    chk("rst.a.len_beats", 32'(a_len_beats), 32'd0);
    chk("rst.a.len_ovf",   32'(a_len_ovf),   32'd0);
    chk("rst.a.active",    32'(a_active),    32'd0);
    chk("rst.a.count_en",  32'(a_count_en),  32'd0);
    chk("rst.a.tready",    32'(a_tready),    32'(dn_tready));
    chk("rst.b.len_valid", 32'(b_len_valid), 32'd0);
    chk("rst.b.active",    32'(b_active),    32'd0);
    m_sum = 0; m_n = 0; m_lv = 0; m_active = 0; rec_sum = 0; rec_n = 0;
    @(negedge clk);
    rst = 1;
  endtask

  initial begin
    rst = 0; clr = 0; s_tvalid = 0; s_tlast = 0; s_tkeep = '0; dn_tready = 0; len_ready = 0;
    m_sum = 0; m_n = 0; m_lv = 0; m_active = 0; rec_sum = 0; rec_n = 0;
    apply_reset();

    // Single beat message, then record drops after handshake
    cycle(1, 1, 8'h0F, 1, 1, 0);
    cycle(0, 0, 8'h00, 1, 1, 0);

    // Three back-to-back beats
    cycle(1, 0, 8'hFF, 1, 1, 0);
    cycle(1, 0, 8'hFF, 1, 1, 0);
    cycle(1, 1, 8'h07, 1, 1, 0);
    cycle(0, 0, 8'h00, 1, 1, 0);

    // Record pending back-pressures the stream; release takes effect same cycle
    cycle(1, 1, 8'h03, 1, 0, 0);
    cycle(1, 0, 8'hFF, 1, 0, 0);
    cycle(1, 0, 8'hFF, 1, 0, 0);
    cycle(0, 0, 8'h00, 1, 1, 0);

    // Byte saturation on the narrow instance, then a clean message
    cycle(1, 0, 8'hFF, 1, 1, 0);
    cycle(1, 0, 8'hFF, 1, 1, 0);
    cycle(1, 1, 8'hFF, 1, 1, 0);
    cycle(1, 1, 8'h01, 1, 1, 0);
    cycle(0, 0, 8'h00, 1, 1, 0);

    // Beat-count saturation with empty keeps, back-to-back with handshake
    for (int i = 0; i < 18; i++) cycle(1, 0, 8'h00, 1, 1, 0);
    cycle(1, 1, 8'h00, 1, 1, 0);
    cycle(1, 1, 8'h80, 1, 1, 0);
    cycle(0, 0, 8'h00, 1, 1, 0);

    // Reset mid-message loses the partial message
    cycle(1, 0, 8'hFF, 1, 1, 0);
    cycle(1, 0, 8'hFF, 1, 1, 0);
    apply_reset();
    cycle(1, 1, 8'h01, 1, 1, 0);
    cycle(0, 0, 8'h00, 1, 1, 0);

    // clr mid-message with a beat in the clr cycle, then clr with record pending
    cycle(1, 0, 8'hFF, 1, 1, 0);
    cycle(1, 1, 8'h03, 1, 1, 1);
    cycle(1, 1, 8'h03, 1, 1, 0);
    cycle(1, 1, 8'h0F, 1, 0, 0);
    cycle(0, 0, 8'h00, 1, 0, 1);
    cycle(1, 1, 8'h03, 1, 1, 0);
    cycle(0, 0, 8'h00, 1, 1, 0);

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      logic [7:0] kp;
      kp = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      cycle(logic'($urandom_range(0, 9) < 7), logic'($urandom_range(0, 3) == 0), kp,
            logic'($urandom_range(0, 9) < 8), logic'($urandom_range(0, 9) < 6),
            logic'($urandom_range(0, 49) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
